mux_arbiter: RTL and testbench

MUX_ARBITER -- requirements
Module: mux_arbiter

---
 rtl/mux_arbiter_if.sv | 29 ++
 rtl/mux_arbiter.sv | 87 ++++++++
 tb/tb_mux_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_if.sv
// Purpose: handshake bundle for the two-source arbiter (A and B inputs, Y output).
// Latency: none; this file only carries wires between the bench/fabric and the arbiter.
// Backpressure: valid/ready on every channel; y_ready stalls the output register.
interface mux_arbiter_if #(
  parameter int W = 8
);
  logic         a_valid;
  logic [W-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [W-1:0] b_data;
  logic         b_ready;
  logic         y_valid;
  logic [W-1:0] y_data;
  logic         y_src;
  logic         y_ready;

  // Arbiter side: consumes the two sources and drives the output register.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, y_src
  );

  // Traffic side: drives the sources and the downstream ready.
  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, y_src
  );
endinterface

// File: rtl/mux_arbiter.sv
// Purpose: two-source burst-limited arbiter feeding a single registered output word.
// Latency: 1 cycle from accepted input to y_valid; full throughput with simultaneous drain/fill.
// Backpressure: y_ready low while FULL holds the word and deasserts both a_ready and b_ready.
module mux_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  mux_arbiter_if.slave   bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t       state_q, state_d;
  logic [W-1:0] y_data_q, y_data_d;
  logic         y_src_q, y_src_d;
  logic         last_src_q, last_src_d;
  logic [3:0]   burst_cnt_q, burst_cnt_d;

  logic accept;
  logic grant_vld;
  logic grant_src;   // 0 = A, 1 = B
  logic xfer;

  // Grant selection and ready generation; the burst limit only matters when both sources compete.
  always_comb begin
    grant_vld = bus.a_valid | bus.b_valid;
    grant_src = 1'b0;
    if (bus.a_valid && bus.b_valid) begin
      grant_src = (burst_cnt_q < MAX_CNT) ? last_src_q : ~last_src_q;
    end else if (bus.b_valid) begin
      grant_src = 1'b1;
    end
    // Reset blocks acceptance so nothing is consumed from a source during reset.
    accept      = ~rst & ((state_q == EMPTY) | bus.y_ready);
    xfer        = accept & grant_vld;
    bus.a_ready = xfer & ~grant_src;
    bus.b_ready = xfer & grant_src;
  end

  // Next-state: load on transfer (covers drain+fill), drain to EMPTY otherwise, else hold.
  always_comb begin
    state_d     = state_q;
    y_data_d    = y_data_q;
    y_src_d     = y_src_q;
    last_src_d  = last_src_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      state_d    = FULL;
      y_data_d   = grant_src ? bus.b_data : bus.a_data;
      y_src_d    = grant_src;
      last_src_d = grant_src;
      if (grant_src == last_src_q) begin
        burst_cnt_d = (burst_cnt_q >= MAX_CNT) ? MAX_CNT : burst_cnt_q + 4'd1;
      end else begin
        burst_cnt_d = 4'd1;
      end
    end else if ((state_q == FULL) && bus.y_ready) begin
      state_d = EMPTY;
    end
  end

  // State registers with synchronous reset that discards the held word and burst history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      y_data_q    <= '0;
      y_src_q     <= 1'b0;
      last_src_q  <= 1'b0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      y_data_q    <= y_data_d;
      y_src_q     <= y_src_d;
      last_src_q  <= last_src_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign bus.y_valid = (state_q == FULL);
  assign bus.y_data  = y_data_q;
  assign bus.y_src   = y_src_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Purpose: directed and randomized checking of mux_arbiter with W=8, MAX_BURST=4.
// Latency: checks the 1-cycle input-to-output latency and zero-bubble streaming.
// Backpressure: exercises y_ready stalls, drain/fill overlap and reset during a burst.
module tb_mux_arbiter;

  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  mux_arbiter_if #(.W(W)) bus ();

  mux_arbiter #(.W(W), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [W-1:0] ad,
                       input logic bv, input logic [W-1:0] bd, input logic yr);
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
    bus.y_ready = yr;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [8:0] sb_q[$];
  logic [8:0] sb_word;
  int         a_seq, b_seq, a_wait;
  logic       av, bv, yr, a_fire, b_fire;
  logic       exp_src;

  initial begin
    // ---------------- reset state, sources valid during reset ----------------
    rst = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 8'hA5, 1'b1);
    tick();
    tick();
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_y_valid", bus.y_valid, 0);
    chk("rst_y_data", bus.y_data, 0);
    chk("rst_y_src", bus.y_src, 0);
    chk("rst_burst", dut.burst_cnt_q, 0);

    // ---------------- first transfer latency ----------------
    rst = 1'b0;
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
    chk("lat_a_ready", bus.a_ready, 1);
    chk("lat_b_ready", bus.b_ready, 0);
    tick();
    chk("lat_y_valid", bus.y_valid, 1);
    chk("lat_y_data", bus.y_data, 8'h11);
    chk("lat_y_src", bus.y_src, 0);
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    chk("drain_empty", bus.y_valid, 0);

    // ---------------- stall while FULL ----------------
    do_reset();
    drive(1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    chk("stall_load_rdy", bus.a_ready, 1);
    tick();
    chk("stall_load", bus.y_data, 8'h22);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
      chk("stall_a_ready", bus.a_ready, 0);
      tick();
      chk("stall_hold_data", bus.y_data, 8'h22);
      chk("stall_hold_vld", bus.y_valid, 1);
    end
    drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
    chk("unstall_a_ready", bus.a_ready, 1);
    tick();
    chk("unstall_data", bus.y_data, 8'h33);
    chk("unstall_vld", bus.y_valid, 1);

    // ---------------- both valid, alternating bursts of 4 ----------------
    do_reset();
    for (int i = 0; i < 10; i++) begin
      exp_src = ((i / 4) % 2) == 1;
      drive(1'b1, 8'(8'hA0 + i), 1'b1, 8'(8'hB0 + i), 1'b1);
      chk("burst_a_ready", bus.a_ready, !exp_src);
      chk("burst_b_ready", bus.b_ready, exp_src);
      tick();
      chk("burst_y_valid", bus.y_valid, 1);
      chk("burst_y_src", bus.y_src, exp_src);
      chk("burst_y_data", bus.y_data, exp_src ? 8'(8'hB0 + i) : 8'(8'hA0 + i));
    end

    // ---------------- lone B past the burst limit, then A arrives ----------------
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h00, 1'b1, 8'(8'hC0 + i), 1'b1);
      chk("lone_b_ready", bus.b_ready, 1);
      tick();
      chk("lone_b_src", bus.y_src, 1);
    end
    chk("lone_b_sat", dut.burst_cnt_q, 4);
    drive(1'b1, 8'h44, 1'b1, 8'hCA, 1'b1);
    chk("swap_a_ready", bus.a_ready, 1);
    chk("swap_b_ready", bus.b_ready, 0);
    tick();
    chk("swap_src", bus.y_src, 0);
    chk("swap_data", bus.y_data, 8'h44);
    chk("swap_cnt", dut.burst_cnt_q, 1);

    // ---------------- reset mid-burst while FULL ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b1);
      tick();
    end
    chk("mid_cnt3", dut.burst_cnt_q, 3);
    chk("mid_full", bus.y_valid, 1);
    rst = 1'b1;
    drive(1'b1, 8'h70, 1'b1, 8'h71, 1'b1);
    chk("mid_rst_a_ready", bus.a_ready, 0);
    chk("mid_rst_b_ready", bus.b_ready, 0);
    tick();
    chk("mid_rst_y_valid", bus.y_valid, 0);
    chk("mid_rst_a_ready2", bus.a_ready, 0);
    chk("mid_rst_b_ready2", bus.b_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", bus.a_ready, 1);
    chk("post_rst_b_ready", bus.b_ready, 0);
    tick();
    chk("post_rst_src", bus.y_src, 0);
    chk("post_rst_data", bus.y_data, 8'h70);

    // ---------------- random stress against a scoreboard ----------------
    do_reset();
    sb_q.delete();
    a_seq  = 0;
    b_seq  = 0;
    a_wait = 0;
    for (int i = 0; i < 400; i++) begin
      av = ($urandom_range(0, 3) != 0);
      bv = ($urandom_range(0, 3) != 0);
      yr = ($urandom_range(0, 2) != 0) || (i >= 380);
      if (i >= 380) begin
        av = 1'b0;
        bv = 1'b0;
      end
      drive(av, {1'b0, 7'(a_seq)}, bv, {1'b1, 7'(b_seq)}, yr);
      a_fire = bus.a_ready & av;
      b_fire = bus.b_ready & bv;
      chk("rnd_excl", bus.a_ready & bus.b_ready, 0);
      if (bus.y_valid && yr) begin
        if (sb_q.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          sb_word = sb_q.pop_front();
          chk("rnd_word", {bus.y_src, bus.y_data}, sb_word);
        end
      end
      if (a_fire) begin
        sb_q.push_back({1'b0, 1'b0, 7'(a_seq)});
        a_seq++;
      end
      if (b_fire) begin
        sb_q.push_back({1'b1, 1'b1, 7'(b_seq)});
        b_seq++;
      end
      if (av && b_fire) begin
        a_wait++;
        chk("rnd_starve_a", (a_wait <= MB), 1);
      end else if (a_fire || !av) begin
        a_wait = 0;
      end
      tick();
    end
    chk("rnd_drained", sb_q.size(), 0);
    chk("rnd_final_empty", bus.y_valid, 0);
    chk("rnd_traffic", (a_seq > 20) && (b_seq > 20), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
